// File: rtl/sc_sched_ctrl.sv
// sc_sched_ctrl: schedule controller for an N=8 successive-cancellation polar
// decoder with four f and four g processing elements. Walks the fixed
// 14-operation SC schedule one op per cycle. Takes hard decisions at stage 0,
// forces frozen leaves to zero, supplies partial-sum signs to g PEs and
// assembles the decoded word under a start/done handshake.
//
// Build option: define SC_SCHED_B2B_EN so that start is accepted in the DONE
// cycle, which lets frames run back-to-back with no IDLE gap.
//
// state  | meaning
// IDLE   | waiting for start; u_hat holds the last decoded word
// RUN    | one schedule op per non-held cycle, op_q = 0..13
// DONE   | single-cycle completion pulse, u_hat complete
module sc_sched_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hold,
    input  logic       llr_sign,
    output logic       busy,
    output logic       llr_load,
    output logic       pe_en,
    output logic       op_g,
    output logic [1:0] op_stage,
    output logic [1:0] op_node,
    output logic [3:0] g_sig,
    output logic       u_valid,
    output logic [2:0] u_idx,
    output logic       u_bit,
    output logic [7:0] u_hat,
    output logic       done
);

    localparam logic [7:0] FROZEN_MASK = 8'b0001_0111;
    localparam logic [3:0] LAST_OP     = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [7:0] u_hat_q, u_hat_d;
    logic       u_valid_q, u_valid_d;
    logic [2:0] u_idx_q, u_idx_d;
    logic       u_bit_q, u_bit_d;

    logic       sch_g;
    logic [1:0] sch_stage;
    logic [1:0] sch_node;
    logic [2:0] dec_idx;
    logic       dec_bit;
    logic       run;
    logic       commit;
    logic       llr_load_c;
    logic [1:0] pair_c;
    logic [3:0] g_sig_c;

    // Fixed SC schedule: op index -> function, stage, node.
    always_comb begin
        sch_g     = 1'b0;
        sch_stage = 2'd0;
        sch_node  = 2'd0;
        case (op_q)
            4'd0:  begin sch_g = 1'b0; sch_stage = 2'd2; sch_node = 2'd0; end
            4'd1:  begin sch_g = 1'b0; sch_stage = 2'd1; sch_node = 2'd0; end
            4'd2:  begin sch_g = 1'b0; sch_stage = 2'd0; sch_node = 2'd0; end
            4'd3:  begin sch_g = 1'b1; sch_stage = 2'd0; sch_node = 2'd0; end
            4'd4:  begin sch_g = 1'b1; sch_stage = 2'd1; sch_node = 2'd0; end
            4'd5:  begin sch_g = 1'b0; sch_stage = 2'd0; sch_node = 2'd1; end
            4'd6:  begin sch_g = 1'b1; sch_stage = 2'd0; sch_node = 2'd1; end
            4'd7:  begin sch_g = 1'b1; sch_stage = 2'd2; sch_node = 2'd0; end
            4'd8:  begin sch_g = 1'b0; sch_stage = 2'd1; sch_node = 2'd1; end
            4'd9:  begin sch_g = 1'b0; sch_stage = 2'd0; sch_node = 2'd2; end
            4'd10: begin sch_g = 1'b1; sch_stage = 2'd0; sch_node = 2'd2; end
            4'd11: begin sch_g = 1'b1; sch_stage = 2'd1; sch_node = 2'd1; end
            4'd12: begin sch_g = 1'b0; sch_stage = 2'd0; sch_node = 2'd3; end
            4'd13: begin sch_g = 1'b1; sch_stage = 2'd0; sch_node = 2'd3; end
            default: begin sch_g = 1'b0; sch_stage = 2'd0; sch_node = 2'd0; end
        endcase
    end

    assign run     = (state_q == S_RUN);
    assign commit  = run & ~hold;
    // A stage-0 op at node k decides leaf 2k (f) or 2k+1 (g).
    assign dec_idx = {sch_node, sch_g};
    assign dec_bit = FROZEN_MASK[dec_idx] ? 1'b0 : llr_sign;

    // Partial-sum signs: re-encode the already decided left-subtree leaves.
    always_comb begin
        g_sig_c = 4'b0000;
        pair_c  = sch_node[0] ? u_hat_q[5:4] : u_hat_q[1:0];
        if (run && sch_g) begin
            case (sch_stage)
                2'd0: g_sig_c[0] = u_hat_q[{sch_node, 1'b0}];
                2'd1: g_sig_c = {2'b00, pair_c[1], pair_c[0] ^ pair_c[1]};
                2'd2: g_sig_c = {u_hat_q[3],
                                 u_hat_q[2] ^ u_hat_q[3],
                                 u_hat_q[1] ^ u_hat_q[3],
                                 ^u_hat_q[3:0]};
                default: g_sig_c = 4'b0000;
            endcase
        end
    end

    // Next-state, op sequencing, decisions and the llr_load pulse.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        u_hat_d    = u_hat_q;
        u_valid_d  = 1'b0;
        u_idx_d    = 3'd0;
        u_bit_d    = 1'b0;
        llr_load_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    llr_load_c = 1'b1;
                    u_hat_d    = 8'h00;
                    op_d       = 4'd0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (commit) begin
                    if (sch_stage == 2'd0) begin
                        u_valid_d        = 1'b1;
                        u_idx_d          = dec_idx;
                        u_bit_d          = dec_bit;
                        u_hat_d[dec_idx] = dec_bit;
                    end
                    if (op_q == LAST_OP) begin
                        op_d    = 4'd0;
                        state_d = S_DONE;
                    end else begin
                        op_d = op_q + 4'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifdef SC_SCHED_B2B_EN
                if (start) begin
                    llr_load_c = 1'b1;
                    u_hat_d    = 8'h00;
                    op_d       = 4'd0;
                    state_d    = S_RUN;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                op_d    = 4'd0;
            end
        endcase
    end

    // State, op counter, decoded word and the registered decision report.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= 4'd0;
            u_hat_q   <= 8'h00;
            u_valid_q <= 1'b0;
            u_idx_q   <= 3'd0;
            u_bit_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            u_hat_q   <= u_hat_d;
            u_valid_q <= u_valid_d;
            u_idx_q   <= u_idx_d;
            u_bit_q   <= u_bit_d;
        end
    end

    // Op fields are only meaningful in RUN; zero elsewhere so IDLE is quiet.
    assign busy     = run;
    assign llr_load = llr_load_c;
    assign pe_en    = commit;
    assign op_g     = run ? sch_g : 1'b0;
    assign op_stage = run ? sch_stage : 2'd0;
    assign op_node  = run ? sch_node : 2'd0;
    assign g_sig    = g_sig_c;
    assign u_valid  = u_valid_q;
    assign u_idx    = u_idx_q;
    assign u_bit    = u_bit_q;
    assign u_hat    = u_hat_q;
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_sc_sched_ctrl.sv
// Scoreboard bench for sc_sched_ctrl. The driver walks SC decoding frames
// from a recursive-structure view of the schedule and pushes expected per-cycle
// op fields, decision reports, llr_load cycles and done results; a negedge
// monitor pops and compares what the DUT presents.
module tb_sc_sched_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, hold, llr_sign;
    logic       busy, llr_load, pe_en, op_g, u_valid, u_bit, done;
    logic [1:0] op_stage, op_node;
    logic [3:0] g_sig;
    logic [2:0] u_idx;
    logic [7:0] u_hat;

    sc_sched_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold), .llr_sign(llr_sign),
        .busy(busy), .llr_load(llr_load), .pe_en(pe_en), .op_g(op_g),
        .op_stage(op_stage), .op_node(op_node), .g_sig(g_sig),
        .u_valid(u_valid), .u_idx(u_idx), .u_bit(u_bit), .u_hat(u_hat),
        .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         hld;
        bit         g;
        int         stage;
        int         node;
        logic [3:0] gsig;
        logic [7:0] uhat;
    } op_exp_t;
    typedef struct { int c; int idx; bit b; } uv_exp_t;
    typedef struct { int c; logic [7:0] uhat; } done_exp_t;

    op_exp_t   op_q[$];
    uv_exp_t   uv_q[$];
    done_exp_t dn_q[$];
    int        ll_q[$];

    logic [7:0] mask_v = 8'b0001_0111;
    bit   sg[14];
    int   ss[14];
    int   sn[14];
    int   n_pass = 0;
    int   n_total = 0;
    bit   mon_en = 1'b0;
    logic [7:0] last_uhat;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // g PE signs are the polar encoding of the left sibling's decided leaves.
    function automatic logic [3:0] gsig_model(bit g, int stage, int node, logic [7:0] u);
        logic [3:0] r;
        int w, base;
        r = 4'b0;
        if (g) begin
            w = 1 << stage;
            base = node * 2 * w;
            for (int j = 0; j < w; j++)
                for (int i = 0; i < w; i++)
                    if ((i & j) == j) r[j] = r[j] ^ u[base + i];
        end
        return r;
    endfunction

    function automatic void push_op(bit hld, int n, logic [7:0] mu);
        op_exp_t e;
        e.hld   = hld;
        e.g     = sg[n];
        e.stage = ss[n];
        e.node  = sn[n];
        e.gsig  = gsig_model(sg[n], ss[n], sn[n], mu);
        e.uhat  = mu;
        op_q.push_back(e);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame, entered in a cycle where the DUT accepts start; returns in
    // the DONE cycle's drive phase.
    task automatic do_frame(input int mode, input int hold_pct, input int hold_op,
                            input int hold_len, input bit keep_start);
        logic [7:0] mu;
        int c0, h, hcnt, idx;
        bit s, b;
        uv_exp_t uv;
        done_exp_t de;
        mu = 8'h00;
        h  = 0;
        c0 = cyc;
        start    = 1'b1;
        hold     = 1'($urandom % 2);
        llr_sign = 1'($urandom % 2);
        ll_q.push_back(cyc);
        step();
        for (int n = 0; n < 14; n++) begin
            hcnt = (n == hold_op) ? hold_len : 0;
            if (n != hold_op)
                for (int r = 0; r < 3; r++)
                    if (int'($urandom % 100) < hold_pct) hcnt++;
            for (int r = 0; r < hcnt; r++) begin
                start    = keep_start ? 1'b1 : 1'($urandom % 2);
                hold     = 1'b1;
                llr_sign = 1'($urandom % 2);
                push_op(1'b1, n, mu);
                h++;
                step();
            end
            start = keep_start ? 1'b1 : 1'($urandom % 2);
            hold  = 1'b0;
            case (mode)
                1:       s = 1'b1;
                2:       s = 1'b0;
                3:       s = cyc[0];
                default: s = 1'($urandom % 2);
            endcase
            llr_sign = s;
            push_op(1'b0, n, mu);
            if (ss[n] == 0) begin
                idx     = 2 * sn[n] + int'(sg[n]);
                b       = mask_v[idx] ? 1'b0 : s;
                mu[idx] = b;
                uv.c    = cyc + 1;
                uv.idx  = idx;
                uv.b    = b;
                uv_q.push_back(uv);
            end
            step();
        end
        de.c    = c0 + 15 + h;
        de.uhat = mu;
        dn_q.push_back(de);
        last_uhat = mu;
        start    = 1'b0;
        hold     = 1'($urandom % 2);
        llr_sign = 1'($urandom % 2);
    endtask

    op_exp_t   m_e;
    uv_exp_t   m_uv;
    done_exp_t m_dn;
    int        m_ll;

    // Monitor: one op entry per RUN cycle; event queues for pulses.
    always @(negedge clk) begin
        if (mon_en) begin
            if (op_q.size() > 0) begin
                m_e = op_q.pop_front();
                check("busy", 32'(busy), 32'd1);
                check("pe_en", 32'(pe_en), 32'(!m_e.hld));
                check("op_g", 32'(op_g), 32'(m_e.g));
                check("op_stage", 32'(op_stage), 32'(m_e.stage));
                check("op_node", 32'(op_node), 32'(m_e.node));
                check("g_sig", 32'(g_sig), 32'(m_e.gsig));
                check("u_hat_run", 32'(u_hat), 32'(m_e.uhat));
            end else begin
                check("quiet_fields", 32'({busy, pe_en, op_g, op_stage, op_node, g_sig}), 32'd0);
            end
            if (llr_load) begin
                if (ll_q.size() == 0) check("llr_load_unexpected", 32'd1, 32'd0);
                else begin
                    m_ll = ll_q.pop_front();
                    check("llr_load_cycle", 32'(cyc), 32'(m_ll));
                end
            end else if (ll_q.size() > 0 && ll_q[0] <= cyc) begin
                m_ll = ll_q.pop_front();
                check("llr_load_missing", 32'd0, 32'd1);
            end
            if (u_valid) begin
                if (uv_q.size() == 0) check("u_valid_unexpected", 32'd1, 32'd0);
                else begin
                    m_uv = uv_q.pop_front();
                    check("u_valid_cycle", 32'(cyc), 32'(m_uv.c));
                    check("u_idx", 32'(u_idx), 32'(m_uv.idx));
                    check("u_bit", 32'(u_bit), 32'(m_uv.b));
                end
            end else if (uv_q.size() > 0 && uv_q[0].c <= cyc) begin
                m_uv = uv_q.pop_front();
                check("u_valid_missing", 32'd0, 32'd1);
            end
            if (done) begin
                if (dn_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
                else begin
                    m_dn = dn_q.pop_front();
                    check("done_cycle", 32'(cyc), 32'(m_dn.c));
                    check("u_hat_done", 32'(u_hat), 32'(m_dn.uhat));
                end
            end else if (dn_q.size() > 0 && dn_q[0].c <= cyc) begin
                m_dn = dn_q.pop_front();
                check("done_missing", 32'd0, 32'd1);
            end
        end
    end

    initial begin
        int k;
        // Schedule from the tree walk: f/g at stage 2, then per half f/g at
        // stage 1, then per quarter f/g at stage 0.
        k = 0;
        for (int a = 0; a < 2; a++) begin
            sg[k] = 1'(a); ss[k] = 2; sn[k] = 0; k++;
            for (int b = 0; b < 2; b++) begin
                sg[k] = 1'(b); ss[k] = 1; sn[k] = a; k++;
                for (int c = 0; c < 2; c++) begin
                    sg[k] = 1'(c); ss[k] = 0; sn[k] = 2 * a + b; k++;
                end
            end
        end

        rst = 1'b1; start = 1'b0; hold = 1'b0; llr_sign = 1'b0;
        repeat (3) step();
        check("reset_outputs",
              32'({busy, llr_load, pe_en, op_g, op_stage, op_node, g_sig,
                   u_valid, u_idx, u_bit, u_hat, done}), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        step();

        do_frame(1, 0, -1, 0, 1'b0);
        check("uhat_all_ones", 32'(u_hat), 32'h0000_00e8);
        step(); step();

        do_frame(2, 0, -1, 0, 1'b0);
        check("uhat_all_zeros", 32'(u_hat), 32'd0);
        step(); step();

        do_frame(3, 0, -1, 0, 1'b0);
        step();

        do_frame(1, 0, 5, 3, 1'b0);
        check("uhat_hold", 32'(u_hat), 32'h0000_00e8);
        step();

        for (int f = 0; f < 20; f++) begin
            do_frame(0, 15, -1, 0, 1'b0);
            step();
            repeat ($urandom % 3) step();
        end

        // Mid-frame reset at op 9, then a fresh decode.
        mon_en = 1'b0;
        start = 1'b1; hold = 1'b0; llr_sign = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        check("op9_stage", 32'(op_stage), 32'(ss[9]));
        check("op9_node", 32'(op_node), 32'(sn[9]));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midframe_reset_outputs",
              32'({busy, llr_load, pe_en, op_g, op_stage, op_node, g_sig,
                   u_valid, u_idx, u_bit, u_hat, done}), 32'd0);
        step();
        mon_en = 1'b1;
        do_frame(0, 10, -1, 0, 1'b0);
        step();

        // start held high across frames.
        for (int f = 0; f < 3; f++) begin
            do_frame(0, 0, -1, 0, 1'b1);
`ifndef SC_SCHED_B2B_EN
            start = 1'b1;
            step();
`endif
        end
        do_frame(0, 0, -1, 0, 1'b1);
        start = 1'b0;
        repeat (4) step();

        check("op_q_drained", 32'(op_q.size()), 32'd0);
        check("uv_q_drained", 32'(uv_q.size()), 32'd0);
        check("done_q_drained", 32'(dn_q.size()), 32'd0);
        check("llr_q_drained", 32'(ll_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
